// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/port types and memory-map constants for mem_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic {PORT_IF, PORT_D} port_t;
    localparam int unsigned INSTR_LIMIT = 1024;
    localparam int unsigned MEM_BYTES   = 4096;
endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: data-first grant selection with a saturating fetch-starvation counter.
module mem_arb_priority #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rest,
    input  logic allow,
    input  logic if_req,
    input  logic d_req,
    output logic if_gnt,
    output logic d_gnt
);
    logic [2:0] starve_q;
    logic       sat;
    always_comb begin
        sat    = starve_q == 3'(STARVE_MAX);
        if_gnt = allow && !rest && if_req && (!d_req || sat);
        d_gnt  = allow && !rest && d_req && !(if_req && sat);
    end
    always_ff @(posedge clk) begin
        if (rest || if_gnt || !if_req)
            starve_q <= '0;
        else if (d_gnt && !sat)
            starve_q <= starve_q + 3'd1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: fetch/data arbiter and sequencer for the shared single-port memory.
// Define MEM_ARB_FAULT_EN to enable grant-time address fault checks.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned INSTR_LIMIT = mem_arb_pkg::INSTR_LIMIT,
    parameter int unsigned MEM_BYTES   = mem_arb_pkg::MEM_BYTES,
    parameter int unsigned STARVE_MAX  = 4
) (
    input  logic              clk,
    input  logic              rest,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import mem_arb_pkg::*;
`ifdef MEM_ARB_FAULT_EN
    localparam bit FAULT_EN = 1'b1;
`else
    localparam bit FAULT_EN = 1'b0;
`endif
    state_t            state_q, state_d;
    port_t             port_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              we_q, fault_q, fault_d, if_fault, d_fault, live, resp_if, resp_d;

    mem_arb_priority #(.STARVE_MAX(STARVE_MAX)) u_priority (
        .clk    (clk),
        .rest   (rest),
        .allow  (state_q != ACCESS),
        .if_req (if_req),
        .d_req  (d_req),
        .if_gnt (if_gnt),
        .d_gnt  (d_gnt)
    );

    // A faulted access keeps its slot timing but never reaches the memory.
    always_comb begin
        if_fault  = 32'(if_addr) >= INSTR_LIMIT || if_addr[0];
        d_fault   = 32'(d_addr) < INSTR_LIMIT || 32'(d_addr) > MEM_BYTES - 2 || d_addr[0];
        fault_d   = FAULT_EN && (if_gnt ? if_fault : d_fault);
        state_d   = rest ? IDLE : state_q == ACCESS ? RESP : (if_gnt || d_gnt) ? ACCESS : IDLE;
        live      = state_q == ACCESS && !fault_q && !rest;
        resp_if   = state_q == ACCESS && port_q == PORT_IF;
        resp_d    = state_q == ACCESS && port_q == PORT_D;
        mem_addr  = live ? addr_q : '0;
        mem_read  = live && port_q == PORT_D && !we_q;
        mem_write = live && port_q == PORT_D && we_q;
        mem_wdata = mem_write ? wdata_q : '0;
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        if (rest) begin
            port_q    <= PORT_IF;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            fault_q   <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (if_gnt || d_gnt) begin
                port_q  <= if_gnt ? PORT_IF : PORT_D;
                addr_q  <= if_gnt ? if_addr : d_addr;
                we_q    <= d_gnt && d_we;
                wdata_q <= d_wdata;
                fault_q <= fault_d;
            end
            if_rvalid <= resp_if;
            d_rvalid  <= resp_d;
            if (resp_if)
                if_rdata <= fault_q ? '0 : mem_rdata;
            if (resp_d)
                d_rdata <= (fault_q || we_q) ? '0 : mem_rdata;
        end
    end

`ifdef MEM_ARB_FAULT_EN
    always_ff @(posedge clk) begin
        if_err <= !rest && resp_if && fault_q;
        d_err  <= !rest && resp_d && fault_q;
    end
`else
    assign if_err = 1'b0;
    assign d_err  = 1'b0;
`endif
endmodule
